// File: rtl/cache_debug_mc_pkg.sv
// Shared cache geometry types, status-word bit positions and FSM encoding
// for the cache debug master controller.
package cache_debug_mc_pkg;

  localparam int TAG_W   = 12;
  localparam int INDEX_W = 6;
  localparam int STATE_W = 2;
  localparam int IO_W    = 2;

  typedef logic [TAG_W-1:0]   addr_tag;
  typedef logic [INDEX_W-1:0] addr_index;
  typedef logic [STATE_W-1:0] line_state;
  typedef logic [31:0]        word;

  // Command payload: io attribute bits above the set index.
  typedef struct packed {
    logic [IO_W-1:0] io;
    addr_index       index;
  } addr_bits;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_VALID     = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_CACHED    = 3;
  localparam int STAT_STATE_LSB = 4;
  localparam int STAT_INDEX_LSB = STAT_STATE_LSB + STATE_W;
  localparam int STAT_TAG_LSB   = STAT_INDEX_LSB + INDEX_W;
  localparam int STATUS_W       = STAT_TAG_LSB + TAG_W;

  typedef enum logic [1:0] {
    DBG_IDLE    = 2'd0,
    DBG_REQ     = 2'd1,
    DBG_CAPTURE = 2'd2
  } dbg_state_e;

  function automatic word pack_status(input logic      busy,
                                      input logic      valid,
                                      input logic      err,
                                      input logic      cached,
                                      input line_state st,
                                      input addr_index idx,
                                      input addr_tag   tag);
    word s;
    s                              = '0;
    s[STAT_BUSY]                   = busy;
    s[STAT_VALID]                  = valid;
    s[STAT_ERR]                    = err;
    s[STAT_CACHED]                 = cached;
    s[STAT_STATE_LSB +: STATE_W]   = st;
    s[STAT_INDEX_LSB +: INDEX_W]   = idx;
    s[STAT_TAG_LSB +: TAG_W]       = tag;
    return s;
  endfunction

endpackage

// File: rtl/cache_debug_sel.sv
// Per-channel multiplexer picking tag, line state and line data of the
// cache channel currently selected for inspection.
module cache_debug_sel
  import cache_debug_mc_pkg::*;
#(
  parameter  int NUM_CACHES = 4,
  parameter  int LINE_WORDS = 4,
  localparam int SEL_W      = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1,
  localparam int LINE_W     = LINE_WORDS * 32
) (
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_CACHES*TAG_W-1:0]   tag_rd,
  input  logic [NUM_CACHES*STATE_W-1:0] state_rd,
  input  logic [NUM_CACHES*LINE_W-1:0]  data_rd,
  output addr_tag                       tag,
  output line_state                     state,
  output logic [LINE_W-1:0]             line
);

  always_comb begin
    tag   = '0;
    state = '0;
    line  = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (sel == SEL_W'(i)) begin
        tag   = tag_rd[i*TAG_W +: TAG_W];
        state = state_rd[i*STATE_W +: STATE_W];
        line  = data_rd[i*LINE_W +: LINE_W];
      end
    end
  end

endmodule

// File: rtl/cache_debug_mc.sv
// Avalon-MM debug master that snapshots one line (tag/state/data) from a
// selected cache channel. Optional CACHE_DEBUG_SCAN_EN: reading the last
// captured word auto-issues a capture of the next index on the same channel.
module cache_debug_mc
  import cache_debug_mc_pkg::*;
#(
  parameter  int NUM_CACHES = 4,
  parameter  int LINE_WORDS = 4,
  parameter  int TIMEOUT    = 255,
  localparam int AW         = $clog2(LINE_WORDS) + 1,
  localparam int LINE_W     = LINE_WORDS * 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AW-1:0]                 dbg_address,
  input  logic                          dbg_read,
  input  logic                          dbg_write,
  input  logic [31:0]                   dbg_writedata,
  output logic                          dbg_waitrequest,
  output logic [31:0]                   dbg_readdata,
  output logic [NUM_CACHES-1:0]         debug_req,
  input  logic [NUM_CACHES-1:0]         debug_ready,
  output addr_index                     debug_index,
  input  logic [NUM_CACHES*TAG_W-1:0]   tag_rd,
  input  logic [NUM_CACHES*STATE_W-1:0] state_rd,
  input  logic [NUM_CACHES*LINE_W-1:0]  data_rd
);

  localparam int OFF_W = AW - 1;
  localparam int SEL_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (STATUS_W > 32) begin : g_status_overflow
    $error("cache_debug_mc: status fields exceed 32 bits");
  end

  dbg_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  addr_index           index_q, index_d;
  logic [IO_W-1:0]     io_q, io_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                cached_q, cached_d;
  line_state           cap_state_q, cap_state_d;
  addr_tag             cap_tag_q, cap_tag_d;
  logic [LINE_W-1:0]   cap_line_q, cap_line_d;

  addr_tag             mux_tag;
  line_state           mux_state;
  logic [LINE_W-1:0]   mux_line;

  logic                win_hit;
  logic [OFF_W-1:0]    win_off;
  logic                busy;
  logic                wr_reg;
  logic                wr_cmd;
  logic                wr_sel;
  logic                scan_issue;
  logic                ready_sel;
  logic [NUM_CACHES-1:0] sel_onehot;
  logic [SEL_W-1:0]    sel_clamped;
  addr_bits            cmd_bits;
  word                 status_word;

  cache_debug_sel #(
    .NUM_CACHES (NUM_CACHES),
    .LINE_WORDS (LINE_WORDS)
  ) u_sel (
    .sel      (sel_q),
    .tag_rd   (tag_rd),
    .state_rd (state_rd),
    .data_rd  (data_rd),
    .tag      (mux_tag),
    .state    (mux_state),
    .line     (mux_line)
  );

  // Bus decode: address MSB picks the captured-word window, else registers.
  always_comb begin
    win_hit     = dbg_address[AW-1];
    win_off     = dbg_address[OFF_W-1:0];
    busy        = (state_q != DBG_IDLE);
    wr_reg      = dbg_write && !win_hit;
    wr_cmd      = wr_reg && !busy && !dbg_address[0];
    wr_sel      = wr_reg && !busy && dbg_address[0];
    cmd_bits    = addr_bits'(dbg_writedata[$bits(addr_bits)-1:0]);
    sel_clamped = (dbg_writedata >= 32'(NUM_CACHES)) ? SEL_W'(NUM_CACHES - 1)
                                                     : dbg_writedata[SEL_W-1:0];
    dbg_waitrequest = !rst && wr_reg && busy;
  end

`ifdef CACHE_DEBUG_SCAN_EN
  always_comb begin
    scan_issue = dbg_read && win_hit && (win_off == OFF_W'(LINE_WORDS - 1)) &&
                 valid_q && !busy && !wr_cmd && !wr_sel;
  end
`else
  always_comb begin
    scan_issue = 1'b0;
  end
`endif

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      sel_onehot[i] = (sel_q == SEL_W'(i));
    end
    ready_sel   = |(debug_ready & sel_onehot);
    debug_req   = (state_q == DBG_REQ) ? sel_onehot : '0;
    debug_index = index_q;
  end

  always_comb begin
    status_word = pack_status(busy, valid_q, err_q, cached_q,
                              cap_state_q, index_q, cap_tag_q);
    dbg_readdata = '0;
    if (!rst && dbg_read) begin
      if (win_hit) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
          if (win_off == OFF_W'(k)) begin
            dbg_readdata = cap_line_q[k*32 +: 32];
          end
        end
      end else if (dbg_address[0]) begin
        dbg_readdata = 32'(sel_q);
      end else begin
        dbg_readdata = status_word;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    index_d     = index_q;
    io_d        = io_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    err_d       = err_q;
    cached_d    = cached_q;
    cap_state_d = cap_state_q;
    cap_tag_d   = cap_tag_q;
    cap_line_d  = cap_line_q;
    unique case (state_q)
      DBG_IDLE: begin
        if (wr_sel) begin
          sel_d = sel_clamped;
        end
        if (wr_cmd) begin
          index_d = cmd_bits.index;
          io_d    = cmd_bits.io;
          cnt_d   = '0;
          state_d = DBG_REQ;
        end else if (scan_issue) begin
          index_d = index_q + addr_index'(1);
          cnt_d   = '0;
          state_d = DBG_REQ;
        end
      end
      DBG_REQ: begin
        // Ready wins over a timeout landing in the same cycle.
        if (ready_sel) begin
          cap_tag_d   = mux_tag;
          cap_state_d = mux_state;
          cap_line_d  = mux_line;
          cached_d    = !(|io_q);
          valid_d     = 1'b1;
          err_d       = 1'b0;
          state_d     = DBG_CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = DBG_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DBG_CAPTURE: begin
        state_d = DBG_IDLE;
      end
      default: begin
        state_d = DBG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DBG_IDLE;
      sel_q       <= '0;
      index_q     <= '0;
      io_q        <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      cached_q    <= 1'b0;
      cap_state_q <= '0;
      cap_tag_q   <= '0;
      cap_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      index_q     <= index_d;
      io_q        <= io_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      cached_q    <= cached_d;
      cap_state_q <= cap_state_d;
      cap_tag_q   <= cap_tag_d;
      cap_line_q  <= cap_line_d;
    end
  end

endmodule

// File: tb/tb_cache_debug_mc.sv
// Randomized self-checking bench for cache_debug_mc against a transaction-level
// model of the debug registers and captured line.
module tb_cache_debug_mc;
  import cache_debug_mc_pkg::*;

  localparam int NC = 4;
  localparam int LW = 4;
  localparam int TO = 255;

  logic               clk;
  logic               rst;
  logic [2:0]         dbg_address;
  logic               dbg_read;
  logic               dbg_write;
  logic [31:0]        dbg_writedata;
  logic               dbg_waitrequest;
  logic [31:0]        dbg_readdata;
  logic [NC-1:0]      debug_req;
  logic [NC-1:0]      debug_ready;
  logic [INDEX_W-1:0] debug_index;
  logic [NC*TAG_W-1:0]   tag_rd;
  logic [NC*STATE_W-1:0] state_rd;
  logic [NC*LW*32-1:0]   data_rd;

  logic [TAG_W-1:0]   ch_tag   [NC];
  logic [STATE_W-1:0] ch_state [NC];
  logic [LW*32-1:0]   ch_line  [NC];

  int n_checks;
  int n_errors;

  // Reference model of the programmer-visible state.
  int                 m_sel;
  logic               m_valid, m_err, m_cached;
  logic [STATE_W-1:0] m_state;
  logic [INDEX_W-1:0] m_index;
  logic [1:0]         m_io;
  logic [TAG_W-1:0]   m_tag;
  logic [LW*32-1:0]   m_line;

  cache_debug_mc #(.NUM_CACHES(NC), .LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .dbg_address     (dbg_address),
    .dbg_read        (dbg_read),
    .dbg_write       (dbg_write),
    .dbg_writedata   (dbg_writedata),
    .dbg_waitrequest (dbg_waitrequest),
    .dbg_readdata    (dbg_readdata),
    .debug_req       (debug_req),
    .debug_ready     (debug_ready),
    .debug_index     (debug_index),
    .tag_rd          (tag_rd),
    .state_rd        (state_rd),
    .data_rd         (data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tag_rd   = '0;
    state_rd = '0;
    data_rd  = '0;
    for (int c = 0; c < NC; c++) begin
      tag_rd[c*TAG_W +: TAG_W]       = ch_tag[c];
      state_rd[c*STATE_W +: STATE_W] = ch_state[c];
      data_rd[c*LW*32 +: LW*32]      = ch_line[c];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    logic [31:0] s;
    s = 32'(busy) + (32'(m_valid) * 2) + (32'(m_err) * 4) + (32'(m_cached) * 8)
      + (32'(m_state) * 16) + (32'(m_index) * 64) + (32'(m_tag) * 4096);
    return s;
  endfunction

  function automatic logic [3:0] onehot(input int s);
    return 4'(1 << s);
  endfunction

  task automatic model_reset();
    m_sel = 0; m_valid = 0; m_err = 0; m_cached = 0; m_state = '0;
    m_index = '0; m_io = '0; m_tag = '0; m_line = '0;
  endtask

  task automatic scramble_channel(input int c);
    ch_tag[c]   = TAG_W'($urandom);
    ch_state[c] = STATE_W'($urandom);
    for (int w = 0; w < LW; w++) ch_line[c][w*32 +: 32] = $urandom;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int stalls);
    dbg_address = a; dbg_writedata = d; dbg_write = 1'b1; stalls = 0;
    @(negedge clk);
    while (dbg_waitrequest && stalls < 600) begin
      stalls++;
      @(negedge clk);
    end
    if (dbg_waitrequest) check_eq("write_stall_bound", 32'(dbg_waitrequest), 32'd0);
    @(posedge clk); #1;
    dbg_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    dbg_address = a; dbg_read = 1'b1;
    @(negedge clk);
    d = dbg_readdata;
    @(posedge clk); #1;
    dbg_read = 1'b0;
  endtask

  // Present ready on the selected channel (with noise elsewhere) for one cycle.
  task automatic pulse_ready();
    scramble_channel(m_sel);
    debug_ready = 4'($urandom) | onehot(m_sel);
    m_tag = ch_tag[m_sel]; m_state = ch_state[m_sel]; m_line = ch_line[m_sel];
    m_valid = 1'b1; m_err = 1'b0; m_cached = (m_io == 2'd0);
    @(posedge clk); #1;
    debug_ready = '0;
    scramble_channel(m_sel);
    check_eq("dreq_in_capture", 32'(debug_req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_words();
    logic [31:0] rd;
    logic        was_valid;
    was_valid = m_valid;
    for (int k = 0; k < LW; k++) begin
      bus_read(3'(4 + k), rd);
      check_eq($sformatf("word%0d", k), rd, m_line[k*32 +: 32]);
    end
`ifdef CACHE_DEBUG_SCAN_EN
    if (was_valid) begin
      m_index = m_index + 1'b1;
      check_eq("scan_dreq", 32'(debug_req), 32'(onehot(m_sel)));
      check_eq("scan_index", 32'(debug_index), 32'(m_index));
      pulse_ready();
    end
`else
    check_eq("no_scan_dreq", 32'(debug_req & {NC{was_valid}}), 32'd0);
`endif
    bus_read(3'd0, rd);
    check_eq("status_after_words", rd, exp_status(1'b0));
  endtask

  task automatic do_txn(input int sv, input int idx, input int io, input int dly);
    int          st;
    logic [31:0] rd;
    bus_write(3'd1, 32'(sv), st);
    m_sel = (sv > NC - 1) ? NC - 1 : sv;
    bus_read(3'd1, rd);
    check_eq("sel_read", rd, 32'(m_sel));
    bus_write(3'd0, 32'((io << 6) | idx), st);
    m_index = INDEX_W'(idx); m_io = 2'(io);
    check_eq("dreq_onehot", 32'(debug_req), 32'(onehot(m_sel)));
    check_eq("debug_index", 32'(debug_index), 32'(m_index));
    bus_read(3'd0, rd);
    check_eq("status_busy", rd, exp_status(1'b1));
    for (int i = 0; i < dly; i++) begin
      debug_ready = (4'($urandom) | 4'b0010) & ~onehot(m_sel);
      @(posedge clk); #1;
      check_eq("dreq_hold", 32'(debug_req), 32'(onehot(m_sel)));
    end
    debug_ready = '0;
    pulse_ready();
    bus_read(3'd0, rd);
    check_eq("status_done", rd, exp_status(1'b0));
    check_words();
  endtask

  initial begin
    logic [31:0] rd;
    int          st, st2;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; dbg_address = '0; dbg_read = 1'b0; dbg_write = 1'b0;
    dbg_writedata = '0; debug_ready = '0;
    for (int c = 0; c < NC; c++) scramble_channel(c);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_waitreq", 32'(dbg_waitrequest), 32'd0);
    check_eq("rst_dreq", 32'(debug_req), 32'd0);
    @(posedge clk); #1;
    bus_read(3'd0, rd); check_eq("rst_status", rd, 32'd0);
    bus_read(3'd1, rd); check_eq("rst_sel", rd, 32'd0);
    check_words();

    // Channel 2, index 0x15, io 0, ready three cycles after issue
    do_txn(2, 'h15, 0, 2);
    // Select clamp with channel-1 noise
    do_txn(7, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 3);

    // Simultaneous read+write of cmd: read shows pre-write status
    dbg_address = 3'd0; dbg_writedata = 32'((2 << 6) | 9); dbg_read = 1'b1; dbg_write = 1'b1;
    @(negedge clk);
    check_eq("rw_pre_value", dbg_readdata, exp_status(1'b0));
    check_eq("rw_no_stall", 32'(dbg_waitrequest), 32'd0);
    @(posedge clk); #1;
    dbg_read = 1'b0; dbg_write = 1'b0;
    m_index = 6'd9; m_io = 2'd2;
    check_eq("rw_dreq", 32'(debug_req), 32'(onehot(m_sel)));
    pulse_ready();
    bus_read(3'd0, rd); check_eq("rw_status", rd, exp_status(1'b0));

    // Word-window writes are dropped without stalling
    dbg_address = 3'd6; dbg_writedata = $urandom; dbg_write = 1'b1;
    @(negedge clk);
    check_eq("win_wr_no_stall", 32'(dbg_waitrequest), 32'd0);
    @(posedge clk); #1;
    dbg_write = 1'b0;
    check_words();

    // Cmd write while busy stalls until IDLE, then second capture completes
    bus_write(3'd1, 32'd1, st); m_sel = 1;
    bus_write(3'd0, 32'(5), st); m_index = 6'd5; m_io = 2'd0;
    fork
      bus_write(3'd0, 32'((1 << 6) | 33), st2);
      begin
        @(posedge clk); #1;
        pulse_ready();
      end
    join
    check_eq("busy_stall_cycles", 32'(st2), 32'd3);
    m_index = 6'd33; m_io = 2'd1;
    check_eq("second_dreq", 32'(debug_req), 32'(onehot(m_sel)));
    check_eq("second_index", 32'(debug_index), 32'd33);
    pulse_ready();
    bus_read(3'd0, rd); check_eq("second_status", rd, exp_status(1'b0));
    check_words();

    // Timeout: no ready for TIMEOUT cycles
    bus_write(3'd0, 32'(44), st); m_index = 6'd44; m_io = 2'd0;
    repeat (TO - 1) @(posedge clk);
    #1 check_eq("timeout_last_req", 32'(debug_req), 32'(onehot(m_sel)));
    @(posedge clk); #1;
    check_eq("timeout_dreq_off", 32'(debug_req), 32'd0);
    m_err = 1'b1; m_valid = 1'b0;
    bus_read(3'd0, rd); check_eq("timeout_status", rd, exp_status(1'b0));
    check_words();

    // Last index: next-index scan when enabled, no side effect otherwise
    do_txn(3, 63, 1, 1);

    for (int t = 0; t < 12; t++) begin
      do_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end

    // Reset during REQ
    bus_write(3'd1, 32'd2, st); m_sel = 2;
    bus_write(3'd0, 32'(17), st);
    @(posedge clk); #1;
    rst = 1'b1; debug_ready = onehot(2);
    @(posedge clk); #1;
    check_eq("rst_req_dreq", 32'(debug_req), 32'd0);
    rst = 1'b0; debug_ready = '0;
    model_reset();
    bus_read(3'd0, rd); check_eq("rst_req_status", rd, 32'd0);
    bus_read(3'd1, rd); check_eq("rst_req_sel", rd, 32'd0);
    check_words();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

endmodule
